// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter
//
// Round-robin request/grant controller with hold limit. NCH requesters compete
// for one shared resource. A grant is held until the owner pulses done, drops
// its request, or the hold timer reaches MAX_HOLD cycles. Each grant is followed
// by a single RELEASE cycle before arbitration resumes. When the timer revokes
// a grant, timeout pulses for that RELEASE cycle.
//
// Optional feature: define ARB_PRIO0_EN to give channel 0 strict priority.
// When it is granted, the round-robin pointer is left unchanged.
//
// Ports:
//   blif_clk_net   in   clock, rising edge
//   blif_reset_net in   asynchronous reset, active-high
//   en             in   arbitration enable, sampled in IDLE only
//   req[NCH]       in   per-channel level request
//   done           in   owner finished, sampled in GRANT only
//   grant[NCH]     out  registered one-hot grant (or zero)
//   grant_id[ID_W] out  index of granted channel; holds last value when idle
//   busy           out  high in GRANT and RELEASE
//   timeout        out  one-cycle pulse when the hold timer revokes a grant
//   hold_cnt       out  cycles elapsed in the current grant

module rr_hold_arbiter #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned HOLD_W   = 4,
    parameter int unsigned MAX_HOLD = 10,
    // Derived from NCH; not meant to be overridden.
    parameter int unsigned ID_W     = $clog2(NCH)
) (
    input  logic              blif_clk_net,
    input  logic              blif_reset_net,
    input  logic              en,
    input  logic [NCH-1:0]    req,
    input  logic              done,
    output logic [NCH-1:0]    grant,
    output logic [ID_W-1:0]   grant_id,
    output logic              busy,
    output logic              timeout,
    output logic [HOLD_W-1:0] hold_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StRelease
    } state_e;

    localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(MAX_HOLD - 1);
    localparam logic [ID_W-1:0]   IdLast   = ID_W'(NCH - 1);

    state_e            state_q, state_d;
    logic [NCH-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;

    logic              sel_valid;
    logic [ID_W-1:0]   sel_id;
    logic [ID_W-1:0]   scan_idx;
    logic [ID_W-1:0]   ptr_next;

    // Round-robin search: first set request at ptr, ptr+1, ... (mod NCH).
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = '0;
        scan_idx  = ptr_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!sel_valid && req[scan_idx]) begin
                sel_valid = 1'b1;
                sel_id    = scan_idx;
            end
            scan_idx = (scan_idx == IdLast) ? '0 : scan_idx + ID_W'(1);
        end
`ifdef ARB_PRIO0_EN
        // Channel 0 overrides the rotation whenever it requests.
        if (req[0]) begin
            sel_valid = 1'b1;
            sel_id    = '0;
        end
`endif
    end

    // Pointer to load when the current grant ends.
    always_comb begin
        ptr_next = (grant_id_q == IdLast) ? '0 : grant_id_q + ID_W'(1);
`ifdef ARB_PRIO0_EN
        if (grant_id_q == '0) begin
            ptr_next = ptr_q;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;
        hold_cnt_d = hold_cnt_q;
        ptr_d      = ptr_q;

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (en && sel_valid) begin
                    state_d    = StGrant;
                    grant_d    = {{(NCH-1){1'b0}}, 1'b1} << sel_id;
                    grant_id_d = sel_id;
                    busy_d     = 1'b1;
                    hold_cnt_d = '0;
                end
            end

            StGrant: begin
                // Priority order: done, request drop, then timer expiry.
                if (done || !req[grant_id_q] || (hold_cnt_q == HoldLast)) begin
                    state_d    = StRelease;
                    grant_d    = '0;
                    hold_cnt_d = '0;
                    ptr_d      = ptr_next;
                    timeout_d  = !done && req[grant_id_q];
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            StRelease: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = StIdle;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            hold_cnt_q <= hold_cnt_d;
            ptr_q      <= ptr_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
    assign timeout  = timeout_q;
    assign hold_cnt = hold_cnt_q;

endmodule

// File: doc/rr_hold_arbiter.md
Name: rr_hold_arbiter

Overview:
- Parametrised request/grant controller for the sequential benchmark family.
- Arbitrates NCH request lines round-robin and holds one grant until the requester signals done, drops its request, or a hold timer expires.
- Replaces fixed-width hand-derived control FSMs with a generic, width- and channel-scalable block.
- Sits between requesting channel logic and a shared resource.

Parameters:
NCH, 4, number of request channels (>=2)
HOLD_W, 4, width of hold counter
MAX_HOLD, 10, max cycles a grant may be held (1..2^HOLD_W-1)
ID_W, $clog2(NCH), width of grant_id (derived, not overridden)

Ports:
blif_clk_net  input  1  clock, rising edge
blif_reset_net  input  1  asynchronous reset, active-high
en  input  1  arbitration enable; sampled in IDLE only
req  input  NCH  per-channel request, level
done  input  1  current owner finished; sampled in GRANT only
grant  output  NCH  one-hot grant, registered
grant_id  output  ID_W  index of granted channel; holds last value when no grant
busy  output  1  high in GRANT and RELEASE
timeout  output  1  one-cycle pulse when a grant is revoked by timer
hold_cnt  output  HOLD_W  cycles elapsed in current grant

Behaviour:
- Reset (async, immediate): state=IDLE, grant=0, grant_id=0, busy=0, timeout=0, hold_cnt=0, rr pointer ptr=0. Reset asserted mid-grant drops grant in the same instant; no RELEASE cycle.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - if en=1 and |req: select first set req[i] searching i=ptr, ptr+1, ... mod NCH.
  - Next edge: grant[i]=1, grant_id=i, busy=1, hold_cnt=0, state=GRANT.
  - Otherwise remain IDLE.
  - Latency: request sampled at edge k -> grant visible after edge k+1.
- GRANT: each cycle evaluate in order:
  - done=1 -> RELEASE, timeout stays 0 (done beats timer on the same cycle).
  - req[grant_id]=0 -> RELEASE, no timeout.
  - hold_cnt==MAX_HOLD-1 -> RELEASE, timeout=1 for exactly the following cycle.
  - else hold_cnt+1.
  - hold_cnt never wraps.
  - en is ignored in GRANT; no pre-emption.
- RELEASE (exactly 1 cycle):
  - grant=0, busy=1, hold_cnt=0.
  - ptr=(grant_id+1) mod NCH.
  - Next state IDLE.
- Minimum spacing between consecutive grants: 3 cycles (GRANT, RELEASE, IDLE).
- ptr wrap: grant_id=NCH-1 -> ptr=0.
- grant is always one-hot or zero; never more than one bit set.
- Outputs are all registered; no combinational input-to-output path.

Optional Feature:
- Macro: ARB_PRIO0_EN.
- Defined:
  - channel 0 is strict priority. In IDLE, req[0]=1 wins regardless of ptr.
  - ptr is not updated after a channel-0 grant.
  - The channel-0 hold limit is still MAX_HOLD.
- Undefined: pure round-robin as above. Channel 0 has no special treatment.

Test Plan:
- Reset then idle: blif_reset_net=1 for 2 cycles, req=4'b1111, en=0 -> grant=0, busy=0, hold_cnt=0 throughout; en=1 -> grant=4'b0001, grant_id=0 one edge later.
- Round-robin rotation: NCH=4, req=4'b1111 held, done pulsed on the 2nd GRANT cycle of each grant -> grant sequence 0001,0010,0100,1000,0001; ptr wrap is verified at 1000->0001.
- Timeout: req=4'b0100, done=0 -> grant=0100 for exactly 10 cycles (hold_cnt 0..9), then RELEASE with timeout=1 for 1 cycle, grant=0; next grant goes to ch2 again after IDLE.
- Done/timeout collision: done=1 on the cycle hold_cnt=9 -> RELEASE with timeout=0.
- Request drop and async reset: grant=0010, req[1] deasserts at hold_cnt=3 -> RELEASE next edge, timeout=0. Separately, assert reset at hold_cnt=5 -> grant=0 before the next clock edge, ptr=0.
- ARB_PRIO0_EN: ptr=2, req=4'b0101 -> grant=0001 (without macro: 0100). After ch0 releases with req=4'b0100 -> grant=0100.
